// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs drained round-robin onto NR_WB_PORTS scoreboard ports.
// Define WB_BYPASS_EN to let a packet arriving at an empty FIFO win a port in the same cycle.
module wb_arbiter #(
  parameter int NR_SRC        = 6,
  parameter int NR_WB_PORTS   = 4,
  parameter int FIFO_DEPTH    = 2,
  parameter int TRANS_ID_BITS = 3,
  parameter int EX_BITS       = 129
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [NR_SRC-1:0]                   src_valid_i,
  input  logic [NR_SRC*TRANS_ID_BITS-1:0]     src_trans_id_i,
  input  logic [NR_SRC*64-1:0]                src_result_i,
  input  logic [NR_SRC*EX_BITS-1:0]           src_ex_i,
  output logic [NR_SRC-1:0]                   src_ready_o,
  output logic [NR_WB_PORTS-1:0]              wb_valid_o,
  output logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB_PORTS*64-1:0]           wb_result_o,
  output logic [NR_WB_PORTS*EX_BITS-1:0]      wb_ex_o,
  output logic                                overflow_o
);

  localparam int PKT_W = TRANS_ID_BITS + 64 + EX_BITS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  logic [PKT_W-1:0] mem_q [NR_SRC][FIFO_DEPTH];
  logic [PKT_W-1:0] mem_d [NR_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NR_SRC];
  logic [PTR_W-1:0] rd_ptr_d [NR_SRC];
  logic [PTR_W-1:0] wr_ptr_q [NR_SRC];
  logic [PTR_W-1:0] wr_ptr_d [NR_SRC];
  logic [CNT_W-1:0] cnt_q [NR_SRC];
  logic [CNT_W-1:0] cnt_d [NR_SRC];
  logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             overflow_q, overflow_d;

  logic [NR_SRC-1:0] full, empty, bypass_sel, head_valid, grant, push, pop;
  logic [PKT_W-1:0]  src_pkt  [NR_SRC];
  logic [PKT_W-1:0]  head_pkt [NR_SRC];
  logic [PKT_W-1:0]  port_pkt [NR_WB_PORTS];
  logic [NR_WB_PORTS-1:0] port_valid;
  logic [RR_W-1:0]   last_idx;
  logic              any_grant;

  always_comb begin
    for (int s = 0; s < NR_SRC; s++) begin
      src_pkt[s] = {src_trans_id_i[s*TRANS_ID_BITS +: TRANS_ID_BITS],
                    src_result_i[s*64 +: 64],
                    src_ex_i[s*EX_BITS +: EX_BITS]};
      full[s]  = (cnt_q[s] == CNT_W'(FIFO_DEPTH));
      empty[s] = (cnt_q[s] == '0);
`ifdef WB_BYPASS_EN
      bypass_sel[s] = empty[s] && src_valid_i[s];
`else
      bypass_sel[s] = 1'b0;
`endif
      head_valid[s] = !empty[s] || bypass_sel[s];
      head_pkt[s]   = bypass_sel[s] ? src_pkt[s] : mem_q[s][rd_ptr_q[s]];
    end
  end

  // Scan from rr_ptr and hand out ports in scan order until they run out.
  always_comb begin : arbitrate
    int n;
    int idx;
    n          = 0;
    idx        = 0;
    grant      = '0;
    port_valid = '0;
    last_idx   = '0;
    any_grant  = 1'b0;
    for (int p = 0; p < NR_WB_PORTS; p++) port_pkt[p] = '0;
    if (!flush_i && !rst_i) begin
      for (int k = 0; k < NR_SRC; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NR_SRC) idx = idx - NR_SRC;
        if (head_valid[idx] && n < NR_WB_PORTS) begin
          grant[idx]    = 1'b1;
          port_valid[n] = 1'b1;
          port_pkt[n]   = head_pkt[idx];
          last_idx      = RR_W'(idx);
          any_grant     = 1'b1;
          n             = n + 1;
        end
      end
    end
  end

  always_comb begin
    wb_valid_o    = port_valid;
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_ex_o       = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      {wb_trans_id_o[p*TRANS_ID_BITS +: TRANS_ID_BITS],
       wb_result_o[p*64 +: 64],
       wb_ex_o[p*EX_BITS +: EX_BITS]} = port_pkt[p];
    end
  end

  // A bypassed winner never touches its FIFO; a full FIFO refuses pushes even when popping.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int s = 0; s < NR_SRC; s++) begin
      pop[s]  = grant[s] && !bypass_sel[s];
      push[s] = src_valid_i[s] && !full[s] && !flush_i && !(grant[s] && bypass_sel[s]);
    end
  end

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    overflow_d = !flush_i && |(src_valid_i & full);
    if (flush_i) begin
      for (int s = 0; s < NR_SRC; s++) begin
        rd_ptr_d[s] = '0;
        wr_ptr_d[s] = '0;
        cnt_d[s]    = '0;
      end
      rr_ptr_d = '0;
    end else begin
      for (int s = 0; s < NR_SRC; s++) begin
        if (push[s]) begin
          mem_d[s][wr_ptr_q[s]] = src_pkt[s];
          wr_ptr_d[s]           = wr_ptr_q[s] + 1'b1;
        end
        if (pop[s]) rd_ptr_d[s] = rd_ptr_q[s] + 1'b1;
        cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
      if (any_grant) begin
        rr_ptr_d = (last_idx == RR_W'(NR_SRC - 1)) ? '0 : last_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NR_SRC; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign src_ready_o = ~full;
  assign overflow_o  = overflow_q;

`ifndef SYNTHESIS
  // Pushing into a full FIFO is an issue-logic bug; it must always be flagged the next cycle.
  overflow_flagged_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (!flush_i && |(src_valid_i & full)) |=> overflow_o);
  push_while_full_c: cover property (@(posedge clk_i) disable iff (rst_i)
    |(src_valid_i & full));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int NS    = 6;
  localparam int NP    = 4;
  localparam int DEPTH = 2;
  localparam int TW    = 3;
  localparam int EXW   = 129;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i, flush_i;
  logic [NS-1:0]    src_valid_i;
  logic [NS*TW-1:0] src_trans_id_i;
  logic [NS*64-1:0] src_result_i;
  logic [NS*EXW-1:0] src_ex_i;
  logic [NS-1:0]    src_ready_o;
  logic [NP-1:0]    wb_valid_o;
  logic [NP*TW-1:0] wb_trans_id_o;
  logic [NP*64-1:0] wb_result_o;
  logic [NP*EXW-1:0] wb_ex_o;
  logic             overflow_o;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.NR_SRC(NS), .NR_WB_PORTS(NP), .FIFO_DEPTH(DEPTH),
               .TRANS_ID_BITS(TW), .EX_BITS(EXW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .src_valid_i(src_valid_i), .src_trans_id_i(src_trans_id_i),
    .src_result_i(src_result_i), .src_ex_i(src_ex_i),
    .src_ready_o(src_ready_o), .wb_valid_o(wb_valid_o),
    .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
    .wb_ex_o(wb_ex_o), .overflow_o(overflow_o)
  );

  typedef struct packed {
    logic [TW-1:0]  id;
    logic [63:0]    res;
    logic [EXW-1:0] ex;
  } pkt_t;

  typedef struct {
    string         name;
    logic          flush;
    logic [NS-1:0] vld;
    logic [NS*TW-1:0] ids;
    logic [63:0]   res;
    logic [NP-1:0] e_valid;
    logic [NP*TW-1:0] e_ids;
    logic [63:0]   e_res0;
    logic [NS-1:0] e_ready;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[$];

  // Reference model: one queue per source plus a scan pointer.
  pkt_t mq[NS][$];
  int   rr;
  logic exp_ovf;

  logic          in_flush;
  logic [NS-1:0] in_vld;
  pkt_t          in_pkt[NS];

  logic [NP-1:0] e_valid;
  pkt_t          e_pkt[NP];
  logic [NS-1:0] e_grant, e_byp;
  int            e_last;
  bit            e_any;

  int checks, passes;
  int ovf_obs, valid_obs, rdy_low_obs;
  logic [7:0] served_now;

  task automatic checkOutput(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic pkt_t rndPkt();
    pkt_t p;
    p.id  = 3'($urandom());
    p.res = {$urandom(), $urandom()};
    p.ex  = {$urandom(), $urandom(), $urandom(), $urandom(), 1'($urandom())};
    return p;
  endfunction

  function automatic logic [NS*TW-1:0] ids6(input int a0, a1, a2, a3, a4, a5);
    return {3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic logic [NP*TW-1:0] ids4(input int a0, a1, a2, a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic addVec(input string n, input logic fl, input logic [NS-1:0] v,
                        input logic [NS*TW-1:0] ids, input logic [63:0] res,
                        input logic [NP-1:0] ev, input logic [NP*TW-1:0] eids,
                        input logic [63:0] eres0);
    vec_t r;
    r.name = n; r.flush = fl; r.vld = v; r.ids = ids; r.res = res;
    r.e_valid = ev; r.e_ids = eids; r.e_res0 = eres0; r.e_ready = '1; r.e_ovf = 1'b0;
    tbl.push_back(r);
  endtask

  task automatic applyStimulus();
    flush_i = in_flush;
    for (int s = 0; s < NS; s++) begin
      src_valid_i[s]                = in_vld[s];
      src_trans_id_i[s*TW +: TW]    = in_pkt[s].id;
      src_result_i[s*64 +: 64]      = in_pkt[s].res;
      src_ex_i[s*EXW +: EXW]        = in_pkt[s].ex;
    end
  endtask

  task automatic modelOutputs();
    int n;
    int s;
    bit cand;
    bit byp;
    pkt_t head;
    n = 0; e_valid = '0; e_grant = '0; e_byp = '0; e_any = 0; e_last = 0;
    for (int p = 0; p < NP; p++) e_pkt[p] = '0;
    if (!in_flush) begin
      for (int k = 0; k < NS; k++) begin
        s = (rr + k) % NS;
        cand = 0; byp = 0; head = '0;
        if (mq[s].size() > 0) begin
          cand = 1; head = mq[s][0];
        end else if (BYP && in_vld[s]) begin
          cand = 1; byp = 1; head = in_pkt[s];
        end
        if (cand && n < NP) begin
          e_valid[n] = 1'b1; e_pkt[n] = head; e_grant[s] = 1'b1; e_byp[s] = byp;
          e_last = s; e_any = 1; n++;
        end
      end
    end
  endtask

  task automatic modelStep(input bit rst);
    int sz[NS];
    if (rst || in_flush) begin
      for (int s = 0; s < NS; s++) mq[s].delete();
      rr = 0; exp_ovf = 1'b0;
      return;
    end
    for (int s = 0; s < NS; s++) sz[s] = mq[s].size();
    exp_ovf = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (e_grant[s] && !e_byp[s]) void'(mq[s].pop_front());
      if (in_vld[s] && !(e_grant[s] && e_byp[s])) begin
        if (sz[s] < DEPTH) mq[s].push_back(in_pkt[s]);
        else exp_ovf = 1'b1;
      end
    end
    if (e_any) rr = (e_last + 1) % NS;
  endtask

  task automatic compareModel(input string tag);
    logic [NP*TW-1:0]  eid;
    logic [NP*64-1:0]  eres;
    logic [NP*EXW-1:0] eex;
    logic [NS-1:0]     erdy;
    eid = '0; eres = '0; eex = '0;
    for (int p = 0; p < NP; p++) begin
      if (e_valid[p]) begin
        eid[p*TW +: TW]    = e_pkt[p].id;
        eres[p*64 +: 64]   = e_pkt[p].res;
        eex[p*EXW +: EXW]  = e_pkt[p].ex;
      end
    end
    for (int s = 0; s < NS; s++) erdy[s] = (mq[s].size() < DEPTH);
    checkOutput({tag, ".valid"}, 640'(wb_valid_o), 640'(e_valid));
    checkOutput({tag, ".trans_id"}, 640'(wb_trans_id_o), 640'(eid));
    checkOutput({tag, ".result"}, 640'(wb_result_o), 640'(eres));
    checkOutput({tag, ".ex"}, 640'(wb_ex_o), 640'(eex));
    checkOutput({tag, ".ready"}, 640'(src_ready_o), 640'(erdy));
    checkOutput({tag, ".overflow"}, 640'(overflow_o), 640'(exp_ovf));
    ovf_obs     += int'(overflow_o);
    valid_obs   += $countones(wb_valid_o);
    rdy_low_obs += int'(src_ready_o != '1);
    served_now = '0;
    for (int p = 0; p < NP; p++)
      if (wb_valid_o[p]) served_now[wb_trans_id_o[p*TW +: TW]] = 1'b1;
  endtask

  task automatic runCycle(input string tag);
    applyStimulus();
    #1;
    modelOutputs();
    compareModel(tag);
    @(posedge clk_i);
    modelStep(1'b0);
    @(negedge clk_i);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    in_flush = 1'b0;
    for (int s = 0; s < NS; s++) begin
      in_vld[s] = 1'b1;
      in_pkt[s] = rndPkt();
    end
    applyStimulus();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i  = 1'b0;
    in_vld = '0;
    modelStep(1'b1);
  endtask

  initial begin
    int gap[NS];
    int maxgap;
    checks = 0; passes = 0; ovf_obs = 0; valid_obs = 0; rdy_low_obs = 0;
    rr = 0; exp_ovf = 1'b0; in_flush = 1'b0; in_vld = '0;
    for (int s = 0; s < NS; s++) in_pkt[s] = '0;

`ifdef WB_BYPASS_EN
    addVec("t1_push",   0, 6'b000001, ids6(3,0,0,0,0,0), 64'h55,  4'b0001, ids4(3,0,0,0), 64'h55);
    addVec("t1_wb",     0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("align_push",0, 6'b100000, ids6(0,0,0,0,0,6), 64'h60,  4'b0001, ids4(6,0,0,0), 64'h65);
    addVec("align_wb",  0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("t2_push",   0, 6'b111111, ids6(0,1,2,3,4,5), 64'h100, 4'b1111, ids4(0,1,2,3), 64'h100);
    addVec("t2_wb1",    0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0011, ids4(4,5,0,0), 64'h104);
    addVec("t2_wb2",    0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("t2_idle",   0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("rr0_push",  0, 6'b100001, ids6(1,0,0,0,0,2), 64'h200, 4'b0011, ids4(1,2,0,0), 64'h200);
    addVec("rr0_wb",    0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0000, ids4(0,0,0,0), 64'h0);
`else
    addVec("t1_push",   0, 6'b000001, ids6(3,0,0,0,0,0), 64'h55,  4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("t1_wb",     0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0001, ids4(3,0,0,0), 64'h55);
    addVec("align_push",0, 6'b100000, ids6(0,0,0,0,0,6), 64'h60,  4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("align_wb",  0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0001, ids4(6,0,0,0), 64'h65);
    addVec("t2_push",   0, 6'b111111, ids6(0,1,2,3,4,5), 64'h100, 4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("t2_wb1",    0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b1111, ids4(0,1,2,3), 64'h100);
    addVec("t2_wb2",    0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0011, ids4(4,5,0,0), 64'h104);
    addVec("t2_idle",   0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("rr0_push",  0, 6'b100001, ids6(1,0,0,0,0,2), 64'h200, 4'b0000, ids4(0,0,0,0), 64'h0);
    addVec("rr0_wb",    0, 6'b000000, ids6(0,0,0,0,0,0), 64'h0,   4'b0011, ids4(1,2,0,0), 64'h200);
`endif

    // Pushes held during reset must not survive it.
    doReset();
    runCycle("reset");

    foreach (tbl[i]) begin
      in_flush = tbl[i].flush;
      in_vld   = tbl[i].vld;
      for (int s = 0; s < NS; s++) begin
        in_pkt[s].id  = tbl[i].ids[s*TW +: TW];
        in_pkt[s].res = tbl[i].res + 64'(s);
        in_pkt[s].ex  = '0;
      end
      applyStimulus();
      #1;
      checkOutput({tbl[i].name, ".valid"}, 640'(wb_valid_o), 640'(tbl[i].e_valid));
      checkOutput({tbl[i].name, ".trans_id"}, 640'(wb_trans_id_o), 640'(tbl[i].e_ids));
      checkOutput({tbl[i].name, ".result0"}, 640'(wb_result_o[63:0]), 640'(tbl[i].e_res0));
      checkOutput({tbl[i].name, ".ready"}, 640'(src_ready_o), 640'(tbl[i].e_ready));
      checkOutput({tbl[i].name, ".overflow"}, 640'(overflow_o), 640'(tbl[i].e_ovf));
      @(posedge clk_i);
      @(negedge clk_i);
    end

    // Saturation: every source pushes whenever it has room; id doubles as source index.
    doReset();
    ovf_obs = 0; rdy_low_obs = 0; maxgap = 0;
    for (int s = 0; s < NS; s++) gap[s] = 0;
    for (int c = 0; c < 30; c++) begin
      for (int s = 0; s < NS; s++) begin
        in_vld[s] = (mq[s].size() < DEPTH);
        in_pkt[s] = rndPkt();
        in_pkt[s].id = 3'(s);
      end
      if (c == 2) valid_obs = 0;
      runCycle("t3");
      if (c >= 1) begin
        for (int s = 0; s < NS; s++) begin
          gap[s] = served_now[s] ? 0 : gap[s] + 1;
          if (gap[s] > maxgap) maxgap = gap[s];
        end
      end
    end
    checkOutput("t3.throughput", 640'(valid_obs), 640'(NP * 28));
    checkOutput("t3.starve_le2", 640'(maxgap <= 2), 640'(1));
    checkOutput("t3.no_overflow", 640'(ovf_obs), 640'(0));
    checkOutput("t3.ready_toggles", 640'(rdy_low_obs > 0), 640'(1));

    // Source 2 ignores its ready flag while the others respect theirs.
    doReset();
    ovf_obs = 0;
    for (int c = 0; c < 12; c++) begin
      for (int s = 0; s < NS; s++) begin
        in_vld[s] = (s == 2) ? 1'b1 : (mq[s].size() < DEPTH);
        in_pkt[s] = rndPkt();
      end
      runCycle("t4");
    end
    checkOutput("t4.overflow_seen", 640'(ovf_obs > 0), 640'(1));

    // Flush with FIFOs loaded and fresh pushes arriving in the same cycle.
    doReset();
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < NS; s++) begin
        in_vld[s] = (mq[s].size() < DEPTH);
        in_pkt[s] = rndPkt();
      end
      runCycle("t5.fill");
    end
    in_flush = 1'b1;
    for (int s = 0; s < NS; s++) begin
      in_vld[s] = 1'b1;
      in_pkt[s] = rndPkt();
    end
    runCycle("t5.flush");
    in_flush = 1'b0;
    in_vld   = '0;
    repeat (3) runCycle("t5.after");

    // Single push into empty FIFOs: same-cycle with bypass, next cycle without.
    doReset();
    for (int s = 0; s < NS; s++) in_pkt[s] = rndPkt();
    in_vld = 6'b010000;
    in_pkt[4].id = 3'd7;
    applyStimulus();
    #1;
    checkOutput("t6.valid_t", 640'(wb_valid_o), BYP ? 640'(1) : 640'(0));
    checkOutput("t6.id_t", 640'(wb_trans_id_o), BYP ? 640'(7) : 640'(0));
    @(posedge clk_i);
    @(negedge clk_i);
    in_vld = '0;
    applyStimulus();
    #1;
    checkOutput("t6.valid_t1", 640'(wb_valid_o), BYP ? 640'(0) : 640'(1));
    checkOutput("t6.id_t1", 640'(wb_trans_id_o), BYP ? 640'(0) : 640'(7));
    checkOutput("t6.ready_t1", 640'(src_ready_o), 640'(6'h3f));
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checkOutput("t6.valid_t2", 640'(wb_valid_o), 640'(0));
    @(negedge clk_i);

    // Random traffic, mostly ready-respecting, with occasional violations and flushes.
    doReset();
    for (int c = 0; c < 400; c++) begin
      in_flush = ($urandom_range(0, 19) == 0);
      for (int s = 0; s < NS; s++) begin
        int r;
        r = $urandom_range(0, 9);
        in_vld[s] = (r < 5) ? (mq[s].size() < DEPTH) : (r == 5);
        in_pkt[s] = rndPkt();
      end
      runCycle("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
